// File: rtl/nibbler_clkgate_pkg.sv
// Shared types for the nibbler clock-gate controller: FSM state encoding
// and the width of the optional gated-cycle statistics counter.
package nibbler_clkgate_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } clkgate_state_e;

  localparam int STATS_W = 32;

  // The datapath may accept work only while its clock is running and settled.
  function automatic logic state_ready(input clkgate_state_e s);
    return (s == ST_RUN) || (s == ST_IDLE);
  endfunction

endpackage

// File: rtl/nibbler_clkgate_dncnt.sv
// Loadable down-counter with zero flag; one instance serves both the idle
// window and the post-wake settle window.
module nibbler_clkgate_dncnt #(
  parameter int CNT_W   = 8,
  parameter int RST_VAL = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CNT_W'(RST_VAL);
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nibbler_clkgate_ctl.sv
// Activity-driven clock-enable controller for nibbler_ClkEnBuf; runs on the free clock.
// Optional NIBBLER_CLKGATE_STATS_EN adds a saturating gated-cycle counter output.
module nibbler_clkgate_ctl
  import nibbler_clkgate_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic busy_i,
  input  logic wake_req_i,
  input  logic force_on_i,
  output logic en_l_o,
  output logic gated_o,
  output logic ready_o,
  output logic wake_ack_o
`ifdef NIBBLER_CLKGATE_STATS_EN
  ,
  output logic [STATS_W-1:0] gated_cycles_o
`endif
);

  localparam logic [CNT_W-1:0] IDLE_LD    = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LD_M1 = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LD_M1 = CNT_W'(WAKE_CYCLES - 1);

  clkgate_state_e   state_q;
  clkgate_state_e   state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             ack_d;

  nibbler_clkgate_dncnt #(
    .CNT_W   (CNT_W),
    .RST_VAL (IDLE_CYCLES)
  ) u_dncnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Next-state and counter control
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = IDLE_LD;
    cnt_dec  = 1'b0;
    ack_d    = 1'b0;
    case (state_q)
      ST_RUN: begin
        cnt_load = 1'b1;
        if (!(busy_i || force_on_i)) begin
          state_d = ST_IDLE;
          cnt_val = IDLE_LD_M1;
        end
      end
      ST_IDLE: begin
        // Activity beats an expiring idle window.
        if (busy_i || wake_req_i || force_on_i) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
        end else if (cnt_zero) begin
          state_d = ST_GATED;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_GATED: begin
        if (wake_req_i || force_on_i) begin
          state_d  = ST_WAKE;
          cnt_load = 1'b1;
          cnt_val  = WAKE_LD_M1;
        end
      end
      ST_WAKE: begin
        // Further requests are absorbed while the clock settles.
        if (cnt_zero) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
          ack_d    = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        cnt_load = 1'b1;
      end
    endcase
  end

  // Registered outputs: en_l_o feeds the ClkEnBuf latch with no logic after the flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      en_l_o     <= 1'b0;
      gated_o    <= 1'b0;
      ready_o    <= 1'b1;
      wake_ack_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_l_o     <= (state_d == ST_GATED);
      gated_o    <= (state_d == ST_GATED);
      ready_o    <= state_ready(state_d);
      wake_ack_o <= ack_d;
    end
  end

`ifdef NIBBLER_CLKGATE_STATS_EN
  logic [STATS_W-1:0] gated_cycles_q;

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Stats: one count per edge that finds the controller in GATED
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_cycles_q <= '0;
    end else if (state_q == ST_GATED) begin
      gated_cycles_q <= sat_inc(gated_cycles_q);
    end
  end

  assign gated_cycles_o = gated_cycles_q;
`endif

endmodule

// File: tb/tb_nibbler_clkgate_ctl.sv
// Directed bench for nibbler_clkgate_ctl with default parameters
// (IDLE_CYCLES=16, WAKE_CYCLES=2); stats checks build with NIBBLER_CLKGATE_STATS_EN.
module tb_nibbler_clkgate_ctl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy_i = 1'b0;
  logic wake_req_i = 1'b0;
  logic force_on_i = 1'b0;
  logic en_l_o;
  logic gated_o;
  logic ready_o;
  logic wake_ack_o;
`ifdef NIBBLER_CLKGATE_STATS_EN
  logic [31:0] gated_cycles_o;
`endif

  int checks = 0;
  int errors = 0;

  nibbler_clkgate_ctl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .busy_i     (busy_i),
    .wake_req_i (wake_req_i),
    .force_on_i (force_on_i),
    .en_l_o     (en_l_o),
    .gated_o    (gated_o),
    .ready_o    (ready_o),
    .wake_ack_o (wake_ack_o)
`ifdef NIBBLER_CLKGATE_STATS_EN
    ,
    .gated_cycles_o (gated_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic b, input logic f);
    busy_i     = b;
    force_on_i = f;
    wake_req_i = 1'b0;
    rst_n      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({en_l_o, gated_o, ready_o, wake_ack_o} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_outputs: got en_l/gated/ready/ack=%b want 0010", {en_l_o, gated_o, ready_o, wake_ack_o});
    end
    step();
    step();
    checks++;
    if ({en_l_o, gated_o, ready_o, wake_ack_o} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_held: got en_l/gated/ready/ack=%b want 0010", {en_l_o, gated_o, ready_o, wake_ack_o});
    end
    rst_n = 1'b1;
  endtask

  // Ends in GATED
  task automatic test_idle_gate();
    do_reset(1'b0, 1'b0);
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 16) begin
        checks++;
        if (en_l_o !== 1'b0 || ready_o !== 1'b1) begin
          errors++;
          $display("FAIL idle_edge16: got en_l=%b ready=%b want 0 1", en_l_o, ready_o);
        end
      end
    end
    checks++;
    if ({en_l_o, gated_o, ready_o, wake_ack_o} !== 4'b1100) begin
      errors++;
      $display("FAIL idle_edge17: got en_l/gated/ready/ack=%b want 1100", {en_l_o, gated_o, ready_o, wake_ack_o});
    end
  endtask

  // Starts in GATED
  task automatic test_wake();
    wake_req_i = 1'b1;
    step();
    checks++;
    if ({en_l_o, gated_o, ready_o, wake_ack_o} !== 4'b0000) begin
      errors++;
      $display("FAIL wake_edge1: got en_l/gated/ready/ack=%b want 0000", {en_l_o, gated_o, ready_o, wake_ack_o});
    end
    step();
    checks++;
    if ({en_l_o, ready_o, wake_ack_o} !== 3'b000) begin
      errors++;
      $display("FAIL wake_edge2: got en_l/ready/ack=%b want 000", {en_l_o, ready_o, wake_ack_o});
    end
    step();
    checks++;
    if ({en_l_o, ready_o, wake_ack_o} !== 3'b011) begin
      errors++;
      $display("FAIL wake_edge3: got en_l/ready/ack=%b want 011", {en_l_o, ready_o, wake_ack_o});
    end
    wake_req_i = 1'b0;
    step();
    checks++;
    if ({en_l_o, ready_o, wake_ack_o} !== 3'b010) begin
      errors++;
      $display("FAIL wake_edge4: got en_l/ready/ack=%b want 010", {en_l_o, ready_o, wake_ack_o});
    end
  endtask

  task automatic test_idle_restart();
    do_reset(1'b0, 1'b0);
    for (int e = 1; e <= 11; e++) step();
    busy_i = 1'b1;
    step();
    checks++;
    if (en_l_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_busy: got en_l=%b ready=%b want 0 1", en_l_o, ready_o);
    end
    busy_i = 1'b0;
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 16) begin
        checks++;
        if (en_l_o !== 1'b0) begin
          errors++;
          $display("FAIL restart_edge16: got en_l=%b want 0", en_l_o);
        end
      end
    end
    checks++;
    if (en_l_o !== 1'b1 || gated_o !== 1'b1) begin
      errors++;
      $display("FAIL restart_edge17: got en_l=%b gated=%b want 1 1", en_l_o, gated_o);
    end
  endtask

  task automatic test_activity_wins();
    do_reset(1'b0, 1'b0);
    for (int e = 1; e <= 16; e++) step();
    busy_i = 1'b1;
    step();
    checks++;
    if (en_l_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_zero: got en_l=%b ready=%b want 0 1", en_l_o, ready_o);
    end
    wake_req_i = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step();
      checks++;
      if (wake_ack_o !== 1'b0 || en_l_o !== 1'b0) begin
        errors++;
        $display("FAIL wake_in_run: cycle %0d got ack=%b en_l=%b want 0 0", e, wake_ack_o, en_l_o);
      end
    end
    wake_req_i = 1'b0;
    busy_i     = 1'b0;
  endtask

  task automatic test_force_on();
    int bad = 0;
    do_reset(1'b0, 1'b1);
    for (int e = 1; e <= 100; e++) begin
      step();
      if (en_l_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL force_hold: got %0d cycles with en_l=1 want 0", bad);
    end
    force_on_i = 1'b0;
    for (int e = 1; e <= 17; e++) step();
    checks++;
    if (en_l_o !== 1'b1) begin
      errors++;
      $display("FAIL force_release_gate: got en_l=%b want 1", en_l_o);
    end
    force_on_i = 1'b1;
    step();
    checks++;
    if (en_l_o !== 1'b0 || ready_o !== 1'b0) begin
      errors++;
      $display("FAIL force_wake_edge1: got en_l=%b ready=%b want 0 0", en_l_o, ready_o);
    end
    step();
    step();
    checks++;
    if (wake_ack_o !== 1'b1 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL force_wake_ack: got ack=%b ready=%b want 1 1", wake_ack_o, ready_o);
    end
    step();
    checks++;
    if (wake_ack_o !== 1'b0 || en_l_o !== 1'b0) begin
      errors++;
      $display("FAIL force_after_ack: got ack=%b en_l=%b want 0 0", wake_ack_o, en_l_o);
    end
    force_on_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset(1'b0, 1'b0);
    for (int e = 1; e <= 17; e++) step();
    checks++;
    if (en_l_o !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: got en_l=%b want 1", en_l_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({en_l_o, gated_o, ready_o} !== 3'b001) begin
      errors++;
      $display("FAIL areset_async: got en_l/gated/ready=%b want 001", {en_l_o, gated_o, ready_o});
    end
    step();
    rst_n = 1'b1;
  endtask

`ifdef NIBBLER_CLKGATE_STATS_EN
  task automatic test_stats();
    do_reset(1'b0, 1'b0);
    for (int e = 1; e <= 17; e++) step();
    checks++;
    if (gated_cycles_o !== 32'd0) begin
      errors++;
      $display("FAIL stats_entry: got %0d want 0", gated_cycles_o);
    end
    for (int e = 1; e <= 39; e++) step();
    wake_req_i = 1'b1;
    step();
    step();
    step();
    wake_req_i = 1'b0;
    step();
    checks++;
    if (gated_cycles_o !== 32'd40) begin
      errors++;
      $display("FAIL stats_count: got %0d want 40", gated_cycles_o);
    end
    for (int e = 1; e <= 17; e++) step();
    @(negedge clk);
    dut.gated_cycles_q = 32'hFFFF_FFFD;
    for (int e = 1; e <= 5; e++) step();
    checks++;
    if (gated_cycles_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL stats_saturate: got %h want ffffffff", gated_cycles_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_gate();
    test_wake();
    test_idle_restart();
    test_activity_wins();
    test_force_on();
    test_async_reset();
`ifdef NIBBLER_CLKGATE_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
